// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared LSTM word sizes, controller states and bus helpers
package lstm_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int UNITS      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_X = 2'd1,
    SETTLE = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  typedef logic [DATA_WIDTH-1:0]       word_t;
  typedef logic [UNITS*DATA_WIDTH-1:0] units_bus_t;

  // Unit 0 occupies the least significant word of a units bus.
  function automatic word_t unit_of(input units_bus_t bus, input int idx);
    return bus[idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic units_bus_t splat(input word_t w);
    units_bus_t bus;
    bus = '0;
    for (int i = 0; i < UNITS; i++) bus[i*DATA_WIDTH +: DATA_WIDTH] = w;
    return bus;
  endfunction

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// rtl/lstm_seq_ctrl_if.sv - sample input and final-state output handshakes
interface lstm_seq_ctrl_if #(
  parameter int DATA_WIDTH = lstm_pkg::DATA_WIDTH,
  parameter int UNITS      = lstm_pkg::UNITS
);
  logic                        x_valid;
  logic                        x_ready;
  logic [DATA_WIDTH-1:0]       x_data;
  logic                        h_valid;
  logic                        h_ready;
  logic [UNITS*DATA_WIDTH-1:0] h_out;
  logic [UNITS*DATA_WIDTH-1:0] c_out;

  modport master (
    output x_valid, x_data, h_ready,
    input  x_ready, h_valid, h_out, c_out
  );

  modport slave (
    input  x_valid, x_data, h_ready,
    output x_ready, h_valid, h_out, c_out
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - steps a combinational LSTM cell over a sample sequence,
// holding the recurrent ht/ct state between timesteps
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH    = lstm_pkg::DATA_WIDTH,
  parameter int UNITS         = lstm_pkg::UNITS,
  parameter int SEQ_LEN_MAX   = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int LEN_W         = $clog2(SEQ_LEN_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LEN_W-1:0]            seq_len,
  lstm_seq_ctrl_if.slave              io,
  output logic [DATA_WIDTH-1:0]       cell_xt,
  output logic [UNITS*DATA_WIDTH-1:0] cell_ht_prev,
  output logic [UNITS*DATA_WIDTH-1:0] cell_ct_prev,
  input  logic [UNITS*DATA_WIDTH-1:0] cell_ht,
  input  logic [UNITS*DATA_WIDTH-1:0] cell_ct,
  output logic                        busy,
  output logic                        done,
  output logic [LEN_W-1:0]            step
);
  import lstm_pkg::*;

  localparam int                 CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(SEQ_LEN_MAX);

  state_t                      state, state_nxt;
  logic [LEN_W-1:0]            len_reg, step_reg, step_next;
  logic [CNT_W-1:0]            cnt;
  logic [DATA_WIDTH-1:0]       xt_reg;
  logic [UNITS*DATA_WIDTH-1:0] ht_reg, ct_reg;
  logic                        done_reg;
  logic                        do_clear, do_accept, do_capture, do_done;

  assign step_next = step_reg + LEN_W'(1);

  // Abort wins over every other transition; it also suppresses capture and done.
  always_comb begin
    state_nxt  = state;
    do_clear   = 1'b0;
    do_accept  = 1'b0;
    do_capture = 1'b0;
    do_done    = 1'b0;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (seq_len == '0) begin
              do_done = 1'b1;
            end else begin
              do_clear  = 1'b1;
              state_nxt = WAIT_X;
            end
          end
        end
        WAIT_X: begin
          if (io.x_valid) begin
            do_accept = 1'b1;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            do_capture = 1'b1;
            state_nxt  = (step_next == len_reg) ? OUTPUT : WAIT_X;
          end
        end
        OUTPUT: begin
          if (io.h_ready) begin
            do_done   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg  <= '0;
      step_reg <= '0;
      cnt      <= '0;
      xt_reg   <= '0;
      ht_reg   <= '0;
      ct_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= do_done;
      if (do_clear) begin
        len_reg  <= (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
        step_reg <= '0;
        xt_reg   <= '0;
        ht_reg   <= '0;
        ct_reg   <= '0;
      end
      if (do_accept) begin
        xt_reg <= io.x_data;
        cnt    <= CNT_LOAD;
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (do_capture) begin
        ht_reg   <= cell_ht;
        ct_reg   <= cell_ct;
        step_reg <= step_next;
      end
    end
  end

  // Cell inputs come only from registers so the cell sees a stable operand set.
  assign cell_xt      = xt_reg;
  assign cell_ht_prev = ht_reg;
  assign cell_ct_prev = ct_reg;
  assign io.h_out     = ht_reg;
  assign io.c_out     = ct_reg;
  assign io.x_ready   = (state == WAIT_X);
  assign io.h_valid   = (state == OUTPUT);
  assign busy         = (state != IDLE);
  assign done         = done_reg;
  assign step         = step_reg;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - self-checking bench for lstm_seq_ctrl with an
// integer cell model (ht = ht_prev + xt, ct = ct_prev + 1)
module tb_lstm_seq_ctrl;
  import lstm_pkg::*;

  localparam int DW   = 32;
  localparam int U    = 4;
  localparam int SMAX = 64;
  localparam int SC   = 4;
  localparam int LW   = $clog2(SMAX + 1);

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [LW-1:0]   seq_len;
  logic [DW-1:0]   cell_xt;
  logic [U*DW-1:0] cell_ht_prev, cell_ct_prev, cell_ht, cell_ct;
  logic            busy, done;
  logic [LW-1:0]   step;

  int checks = 0;
  int errors = 0;

  lstm_seq_ctrl_if #(.DATA_WIDTH(DW), .UNITS(U)) io ();

  lstm_seq_ctrl #(
    .DATA_WIDTH(DW), .UNITS(U), .SEQ_LEN_MAX(SMAX), .SETTLE_CYCLES(SC), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len(seq_len),
    .io(io),
    .cell_xt(cell_xt), .cell_ht_prev(cell_ht_prev), .cell_ct_prev(cell_ct_prev),
    .cell_ht(cell_ht), .cell_ct(cell_ct),
    .busy(busy), .done(done), .step(step)
  );

  always #5 clk = ~clk;

  always_comb begin
    cell_ht = '0;
    cell_ct = '0;
    for (int i = 0; i < U; i++) begin
      cell_ht[i*DW +: DW] = cell_ht_prev[i*DW +: DW] + cell_xt;
      cell_ct[i*DW +: DW] = cell_ct_prev[i*DW +: DW] + 32'd1;
    end
  end

  typedef struct {
    int len;
    int xbase;
    int xinc;
    int hold;
    int exp_cyc;
    int exp_h;
    int exp_c;
    int exp_step;
  } run_rec_t;

  run_rec_t tbl[5];

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_units(input string name, input logic [U*DW-1:0] bus, input int exp);
    for (int i = 0; i < U; i++)
      chk($sformatf("%s[%0d]", name, i), 64'(unit_of(bus, i)), 64'(DW'(exp)));
  endtask

  // Hand over the final state and confirm the one-cycle done pulse.
  task automatic finish_handshake(input string tag);
    io.h_ready = 1'b1;
    nxt();
    chk({tag, "_done_pulse"}, 64'(done), 64'(1));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    chk({tag, "_hvalid_after"}, 64'(io.h_valid), 64'(0));
    io.h_ready = 1'b0;
    nxt();
    chk({tag, "_done_single"}, 64'(done), 64'(0));
  endtask

  // Entered and left at a negedge with the controller idle.
  task automatic run_rec(input string tag, input run_rec_t r);
    int idx = 0;
    int t   = 0;
    int bad = 0;
    start      = 1'b1;
    seq_len    = LW'(r.len);
    io.x_valid = 1'b1;
    io.x_data  = DW'(r.xbase);
    nxt();
    t     = 1;
    start = 1'b0;
    chk({tag, "_xready_c1"}, 64'(io.x_ready), 64'(1));
    chk({tag, "_busy_c1"}, 64'(busy), 64'(1));
    while (!io.h_valid && t < 400) begin
      if (io.x_ready) begin
        io.x_data = DW'(r.xbase + idx * r.xinc);
        idx++;
      end
      nxt();
      t++;
    end
    io.x_valid = 1'b0;
    chk({tag, "_hvalid_cycle"}, 64'(t), 64'(r.exp_cyc));
    chk({tag, "_accepts"}, 64'(idx), 64'(r.exp_step));
    chk_units({tag, "_h_out"}, io.h_out, r.exp_h);
    chk_units({tag, "_c_out"}, io.c_out, r.exp_c);
    chk({tag, "_step"}, 64'(step), 64'(r.exp_step));
    chk({tag, "_no_early_done"}, 64'(done), 64'(0));
    for (int i = 0; i < r.hold; i++) begin
      nxt();
      if (!io.h_valid || io.h_out !== splat(DW'(r.exp_h)) || done) bad++;
    end
    if (r.hold > 0) chk({tag, "_hold_stable"}, 64'(bad), 64'(0));
    finish_handshake(tag);
  endtask

  // Random runs: reference is the accepted-sample sum per unit and len for ct.
  task automatic random_runs(input int n);
    for (int r = 0; r < n; r++) begin
      int   len;
      int   q[$];
      int   exp_h = 0;
      int   sa = 100;
      int   bad = 0;
      int   t = 0;
      int   waitn;
      logic hit;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        q.push_back(int'($urandom_range(0, 65535)));
        exp_h += q[i];
      end
      start   = 1'b1;
      seq_len = LW'(len);
      nxt();
      start = 1'b0;
      while (!io.h_valid && t < 500) begin
        sa++;
        if (sa < SC + 1 && (io.x_ready || io.h_valid)) bad++;
        if (sa == SC + 1 && !(io.x_ready || io.h_valid)) bad++;
        hit        = ($urandom_range(0, 9) < 7);
        io.x_valid = hit;
        io.x_data  = $urandom;
        if (io.x_ready && hit && q.size() > 0) begin
          io.x_data = DW'(q.pop_front());
          sa = 0;
        end
        start   = ($urandom_range(0, 7) == 0);
        seq_len = LW'($urandom_range(0, 20));
        nxt();
        t++;
      end
      start      = 1'b0;
      io.x_valid = 1'b0;
      chk($sformatf("rnd%0d_reached_output", r), 64'(io.h_valid), 64'(1));
      chk($sformatf("rnd%0d_spacing", r), 64'(bad), 64'(0));
      chk($sformatf("rnd%0d_all_consumed", r), 64'(q.size()), 64'(0));
      waitn = $urandom_range(0, 3);
      for (int i = 0; i < waitn; i++) nxt();
      chk_units($sformatf("rnd%0d_h_out", r), io.h_out, exp_h);
      chk_units($sformatf("rnd%0d_c_out", r), io.c_out, len);
      chk($sformatf("rnd%0d_step", r), 64'(step), 64'(len));
      finish_handshake($sformatf("rnd%0d", r));
    end
  endtask

  initial begin
    int idx;
    int t;
    tbl[0] = '{3,   1, 1,  0,  16,  6,  3,  3};
    tbl[1] = '{1,   5, 0,  0,   6,  5,  1,  1};
    tbl[2] = '{4,   1, 0,  0,  21,  4,  4,  4};
    tbl[3] = '{2,   3, 1, 10,  11,  7,  2,  2};
    tbl[4] = '{100, 1, 0,  0, 321, 64, 64, 64};

    rst = 1'b1; start = 1'b0; abort = 1'b0; seq_len = '0;
    io.x_valid = 1'b0; io.x_data = '0; io.h_ready = 1'b0;
    repeat (3) nxt();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_x_ready", 64'(io.x_ready), 64'(0));
    chk("rst_h_valid", 64'(io.h_valid), 64'(0));
    chk("rst_step", 64'(step), 64'(0));
    chk("rst_cell_xt", 64'(cell_xt), 64'(0));
    chk("rst_ht_prev", 64'(cell_ht_prev != '0), 64'(0));
    chk("rst_ct_prev", 64'(cell_ct_prev != '0), 64'(0));
    chk("rst_h_out", 64'(io.h_out != '0), 64'(0));
    chk("rst_c_out", 64'(io.c_out != '0), 64'(0));
    rst = 1'b0;
    nxt();
    chk("post_rst_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 5; i++) run_rec($sformatf("tbl%0d", i), tbl[i]);

    // Zero-length run completes immediately without ever leaving IDLE.
    start = 1'b1; seq_len = '0;
    nxt();
    start = 1'b0;
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_x_ready", 64'(io.x_ready), 64'(0));
    nxt();
    chk("zero_done_single", 64'(done), 64'(0));
    chk("zero_h_valid", 64'(io.h_valid), 64'(0));

    // Abort in the SETTLE of step 2 leaves step-1 state in place.
    start = 1'b1; seq_len = LW'(4); io.x_valid = 1'b1; io.x_data = 32'd1;
    nxt();
    start = 1'b0;
    idx = 0; t = 0;
    while (idx < 2 && t < 50) begin
      if (io.x_ready) begin
        io.x_data = DW'(idx + 1);
        idx++;
      end
      nxt();
      t++;
    end
    io.x_valid = 1'b0;
    chk("abort_reached_step2", 64'(idx), 64'(2));
    abort = 1'b1;
    nxt();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_h_valid", 64'(io.h_valid), 64'(0));
    chk("abort_step_kept", 64'(step), 64'(1));
    chk("abort_ht_kept", 64'(unit_of(cell_ht_prev, 0)), 64'(1));
    chk("abort_xt_kept", 64'(cell_xt), 64'(2));
    nxt();
    chk("abort_no_late_done", 64'(done), 64'(0));
    run_rec("after_abort", tbl[1]);

    // Samples offered in IDLE are not taken.
    io.x_valid = 1'b1; io.x_data = 32'd99;
    repeat (3) nxt();
    chk("idle_x_busy", 64'(busy), 64'(0));
    chk("idle_x_ready", 64'(io.x_ready), 64'(0));
    chk("idle_x_cell_xt", 64'(cell_xt), 64'(5));

    // start during WAIT_X and x_valid during SETTLE are ignored.
    io.x_valid = 1'b0;
    start = 1'b1; seq_len = LW'(2);
    nxt();
    seq_len = LW'(9);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait_start_xready%0d", i), 64'(io.x_ready), 64'(1));
      chk($sformatf("wait_start_step%0d", i), 64'(step), 64'(0));
      nxt();
    end
    start = 1'b0;
    io.x_valid = 1'b1; io.x_data = 32'd10;
    nxt();
    io.x_data = 32'd77; start = 1'b1;
    for (int i = 0; i < SC; i++) begin
      chk($sformatf("settle_xt%0d", i), 64'(cell_xt), 64'(10));
      chk($sformatf("settle_xready%0d", i), 64'(io.x_ready), 64'(0));
      nxt();
    end
    start = 1'b0;
    chk("settle_next_xready", 64'(io.x_ready), 64'(1));
    chk("settle_step1", 64'(step), 64'(1));
    io.x_data = 32'd20;
    nxt();
    io.x_valid = 1'b0;
    t = 0;
    while (!io.h_valid && t < 20) begin
      nxt();
      t++;
    end
    chk("ign_h_valid", 64'(io.h_valid), 64'(1));
    chk_units("ign_h_out", io.h_out, 30);
    chk_units("ign_c_out", io.c_out, 2);
    chk("ign_step", 64'(step), 64'(2));
    finish_handshake("ign");

    random_runs(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
